// File: rtl/systolic_result_drain.sv
// Result drain for the vector systolic array: de-skews per-row accumulator vectors into
// ping-pong tile buffers and streams complete tiles out row by row over valid/ready.
module systolic_result_drain #(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned LANES     = 8,
  parameter int unsigned ROWS      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_WIDTH-1:0]       c_in [ROWS-1:0][LANES-1:0],
  input  logic [ROWS-1:0]            c_in_valid,
  output logic [REG_WIDTH-1:0]       out_data [LANES-1:0],
  output logic [$clog2(ROWS)-1:0]    out_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  // Tile storage: [bank][row][lane]; never reset, validity is tracked by r_cap.
  logic [REG_WIDTH-1:0] r_buf [2][ROWS][LANES];

  logic [ROWS-1:0] r_cap [2];
  logic [ROWS-1:0] r_cap_d [2];
  logic [ROWS-1:0] r_wr_sel, r_wr_sel_d;
  logic            r_rd_bank, r_rd_bank_d;
  logic [RowW-1:0] r_rd_row, r_rd_row_d;
  logic            r_ovf, r_ovf_d;

  logic [1:0]      w_full;
  logic            w_valid;
  logic            w_fire;
  logic            w_tile_done;
  logic [ROWS-1:0] w_cap_en;
  logic [ROWS-1:0] w_drop;

  // Capture decisions use only pre-edge masks, so a bank being cleared by its final
  // drain beat still looks full and rejects writes in that same cycle.
  always_comb begin
    w_full[0] = &r_cap[0];
    w_full[1] = &r_cap[1];
    w_valid     = w_full[r_rd_bank];
    w_fire      = w_valid & out_ready;
    w_tile_done = w_fire & (r_rd_row == LastRow);
    w_cap_en    = '0;
    w_drop      = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (c_in_valid[r]) begin
        if (r_cap[r_wr_sel[r]][r]) w_drop[r]   = 1'b1;
        else                       w_cap_en[r] = 1'b1;
      end
    end
  end

  always_comb begin
    r_cap_d[0] = r_cap[0];
    r_cap_d[1] = r_cap[1];
    if (w_tile_done) r_cap_d[r_rd_bank] = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (w_cap_en[r]) r_cap_d[r_wr_sel[r]][r] = 1'b1;
    end
    r_wr_sel_d  = r_wr_sel ^ w_cap_en;
    r_rd_bank_d = r_rd_bank ^ w_tile_done;
    r_rd_row_d  = r_rd_row;
    if (w_tile_done)  r_rd_row_d = '0;
    else if (w_fire)  r_rd_row_d = r_rd_row + 1'b1;
    r_ovf_d = (|w_drop) | (r_ovf & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap[0]  <= '0;
      r_cap[1]  <= '0;
      r_wr_sel  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_row  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_cap[0]  <= r_cap_d[0];
      r_cap[1]  <= r_cap_d[1];
      r_wr_sel  <= r_wr_sel_d;
      r_rd_bank <= r_rd_bank_d;
      r_rd_row  <= r_rd_row_d;
      r_ovf     <= r_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(ROWS); r++) begin
      if (w_cap_en[r]) begin
        for (int l = 0; l < int'(LANES); l++) begin
          r_buf[r_wr_sel[r]][r][l] <= c_in[r][l];
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      out_data[l] = r_buf[r_rd_bank][r_rd_row][l];
    end
    out_row   = r_rd_row;
    out_valid = w_valid;
    out_last  = w_valid & (r_rd_row == LastRow);
    overflow  = r_ovf;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Collects finished accumulator vectors from the edge of the vector systolic PE array, where each array row delivers its lane vector one cycle later than the row above.
- De-skews the rows into complete result tiles in a ping-pong pair of tile buffers.
- Streams each complete tile out row by row over a valid/ready interface, so the array can keep computing while the previous tile drains.

Parameters:
- REG_WIDTH, 16, width of one lane element, matching the PE accumulator width.
- LANES, 8, lanes per row vector.
- ROWS, 8, array rows per tile; must be 2 or more.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- c_in, input, [REG_WIDTH-1:0] c_in[ROWS-1:0][LANES-1:0], accumulator vector from each array row.
- c_in_valid, input, ROWS, per-row strobe; c_in[r] is valid when c_in_valid[r]=1.
- out_data, output, [REG_WIDTH-1:0] out_data[LANES-1:0], the row vector currently presented.
- out_row, output, $clog2(ROWS), row index of out_data within the tile.
- out_valid, output, 1, out_data holds a valid beat.
- out_ready, input, 1, downstream accepts the beat.
- out_last, output, 1, the current beat is the final row of the tile.
- overflow, output, 1, sticky flag: a row vector was dropped.
- clr_ovf, input, 1, clears overflow.

Behaviour:
- **Reset** (synchronous, on the edge where rst=1):
  - Clears both bank capture masks cap[b][ROWS-1:0], all per-row write selectors wr_sel[r], rd_bank, rd_row and overflow.
  - From the cycle after, out_valid=0, out_last=0, out_row=0, overflow=0.
  - Buffer data is not reset; out_data is don't-care while out_valid=0.
  - rst overrides every other input in that cycle, including mid-fill and mid-drain; partially captured tiles are discarded.
- **Capture** (independent per row r):
  - If c_in_valid[r]=1 and cap[wr_sel[r]][r]=0 (value sampled before this edge): store c_in[r] into bank wr_sel[r], row r; set cap[wr_sel[r]][r]; toggle wr_sel[r].
  - If c_in_valid[r]=1 and cap[wr_sel[r]][r]=1: drop the vector, set overflow, leave wr_sel[r] and buffers unchanged.
  - All rows may capture in the same cycle.
- **Full bank:** a bank is full when its cap mask is all ones.
  - It is read-only until it is drained.
  - A capture aimed at a bank in the same cycle that bank is cleared by its final drain beat is dropped and flags overflow; the pre-edge mask governs the decision.
- **Drain:**
  - out_valid = bank rd_bank is full. This asserts in the cycle after the edge that captured that bank's last missing row, so capture-to-output latency is 1 cycle.
  - out_data = bank[rd_bank][rd_row]; out_row = rd_row; out_last = out_valid && rd_row==ROWS-1.
  - On out_valid && out_ready, when rd_row<ROWS-1: rd_row increments.
  - On out_valid && out_ready, when rd_row==ROWS-1: rd_row returns to 0, cap[rd_bank] clears to all zeros, and rd_bank toggles.
  - If the other bank is already full, out_valid stays 1 with no bubble.
- **Backpressure:** while out_valid=1 and out_ready=0, out_data, out_row and out_last hold stable, and the presented bank is never overwritten.
- **Ordering:** tiles are emitted strictly in completion order (bank 0, 1, 0, ...); rows go out 0..ROWS-1.
- **Overflow:**
  - clr_ovf=1 clears overflow on the next edge.
  - A drop in the same cycle as clr_ovf wins, so overflow is set.
- **Arithmetic:** none. Values pass through bit-exact with no truncation or sign handling.

Test Plan:
1. **Reset:** hold rst 2 cycles with random c_in_valid -> out_valid=0, out_last=0, overflow=0 after the reset edge; no beat emitted.
2. **Skewed fill:** drive c_in_valid[r] at cycle r (r=0..7) with c_in[r][l]=16'h100*r+l, out_ready=1 -> out_valid first high at cycle 8. Then 8 consecutive beats with out_row 0..7 and out_data[l]=16'h100*r+l; out_last only on out_row=7; out_valid=0 afterwards.
3. **Backpressure:** same tile, out_ready=0 for cycles 8-12, then toggling 1,0,1 -> beat 0 held stable through the stall; every row emitted exactly once, in order.
4. **Ping-pong:** tile A as in test 2; tile B row r at cycle 8+r with values 16'hB000+16*r+l; out_ready=0 until cycle 20 -> 16 beats with no gap: A rows 0-7, then B rows 0-7; overflow=0.
5. **Overflow:** with both banks full and out_ready=0, pulse c_in_valid[0] with 16'hDEAD -> overflow=1 next cycle; drained data matches A and B with no DEAD value. Pulse clr_ovf -> overflow=0.
6. **Reset mid-drain:** assert rst after 3 accepted beats of tile A with tile B full -> out_valid=0 the next cycle. A fresh skewed tile then drains from row 0 with correct data.
